// File: rtl/frog_game_ctrl.sv
// Game-state controller for the lane-crossing VGA game.
// Accumulates per-lane frog/hazard overlap across a frame and sequences
// PLAY / DEAD / WIN / OVER with a lives counter, level progression and a
// timed status-screen hold.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   PLAY  | frog moving; overlap and win requests accumulated per frame
//   DEAD  | death screen held for HOLD_CYCLES, then respawn or game over
//   WIN   | win screen held for HOLD_CYCLES, then level up and respawn
//   OVER  | out of lives; waits for i_start to begin a fresh game
module frog_game_ctrl #(
  parameter int N_LANES     = 6,
  parameter int N_LIVES     = 3,
  parameter int MAX_LEVEL   = 7,
  parameter int BASE_LANES  = 2,
  parameter int HOLD_CYCLES = 300000000,
  parameter int LVL_W       = (MAX_LEVEL > 0) ? $clog2(MAX_LEVEL + 1) : 1,
  parameter int CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_animate,
  input  logic               i_frog_px,
  input  logic [N_LANES-1:0] i_hazard_px,
  input  logic               i_win,
  input  logic               i_start,
  output logic [1:0]         o_mode,
  output logic [3:0]         o_lives,
  output logic [LVL_W-1:0]   o_level,
  output logic [N_LANES-1:0] o_lane_mask,
  output logic [N_LANES-1:0] o_hit_lane,
  output logic               o_frog_rst
);

  typedef enum logic [1:0] {
    MODE_PLAY = 2'd0,
    MODE_DEAD = 2'd1,
    MODE_WIN  = 2'd2,
    MODE_OVER = 2'd3
  } mode_t;

  localparam logic [3:0]       LIVES_INIT = 4'(N_LIVES);
  localparam logic [LVL_W-1:0] LEVEL_TOP  = LVL_W'(MAX_LEVEL);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  mode_t              mode_q,     mode_d;
  logic [3:0]         lives_q,    lives_d;
  logic [LVL_W-1:0]   level_q,    level_d;
  logic [N_LANES-1:0] hit_lane_q, hit_lane_d;
  logic [N_LANES-1:0] hit_acc_q,  hit_acc_d;
  logic               win_pend_q, win_pend_d;
  logic               frog_rst_q, frog_rst_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [N_LANES-1:0] lane_mask;
  logic [N_LANES-1:0] hit_now;
  logic               win_now;
  logic               hold_done;

  // Live lanes grow with level: lanes 0..BASE_LANES+level-1, capped by N_LANES
  // because k never reaches N_LANES.
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (k < BASE_LANES + int'(level_q)) begin
        lane_mask[k] = 1'b1;
      end
    end
  end

  // This cycle's overlap and win folded into the frame accumulators, so the
  // animate-cycle decision sees the pixel of that same cycle.
  always_comb begin
    hit_now   = hit_acc_q | ({N_LANES{i_frog_px}} & i_hazard_px & lane_mask);
    win_now   = win_pend_q | i_win;
    hold_done = (hold_cnt_q == HOLD_LAST);
  end

  // Next-state and registered-output computation.
  always_comb begin
    mode_d     = mode_q;
    lives_d    = lives_q;
    level_d    = level_q;
    hit_lane_d = hit_lane_q;
    hit_acc_d  = hit_acc_q;
    win_pend_d = win_pend_q;
    frog_rst_d = 1'b0;
    hold_cnt_d = hold_cnt_q;

    unique case (mode_q)
      MODE_PLAY: begin
        hold_cnt_d = '0;
        if (i_animate) begin
          hit_acc_d  = '0;
          win_pend_d = 1'b0;
          if (hit_now != '0) begin
            // death wins over a same-frame goal
            mode_d     = MODE_DEAD;
            lives_d    = lives_q - 4'd1;
            hit_lane_d = hit_now;
          end else if (win_now) begin
            mode_d = MODE_WIN;
          end
        end else begin
          hit_acc_d  = hit_now;
          win_pend_d = win_now;
        end
      end

      MODE_DEAD: begin
        hit_acc_d  = '0;
        win_pend_d = 1'b0;
        if (hold_done) begin
          hold_cnt_d = '0;
          if (lives_q != 4'd0) begin
            mode_d     = MODE_PLAY;
            frog_rst_d = 1'b1;
          end else begin
            mode_d = MODE_OVER;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      MODE_WIN: begin
        hit_acc_d  = '0;
        win_pend_d = 1'b0;
        if (hold_done) begin
          hold_cnt_d = '0;
          mode_d     = MODE_PLAY;
          frog_rst_d = 1'b1;
          if (level_q != LEVEL_TOP) begin
            level_d = level_q + LVL_W'(1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      MODE_OVER: begin
        hit_acc_d  = '0;
        win_pend_d = 1'b0;
        hold_cnt_d = '0;
        if (i_start) begin
          mode_d     = MODE_PLAY;
          lives_d    = LIVES_INIT;
          level_d    = '0;
          hit_lane_d = '0;
          frog_rst_d = 1'b1;
        end
      end

      default: begin
        mode_d = MODE_PLAY;
      end
    endcase
  end

  // State register with synchronous reset; reset never pulses frog_rst.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q     <= MODE_PLAY;
      lives_q    <= LIVES_INIT;
      level_q    <= '0;
      hit_lane_q <= '0;
      hit_acc_q  <= '0;
      win_pend_q <= 1'b0;
      frog_rst_q <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      lives_q    <= lives_d;
      level_q    <= level_d;
      hit_lane_q <= hit_lane_d;
      hit_acc_q  <= hit_acc_d;
      win_pend_q <= win_pend_d;
      frog_rst_q <= frog_rst_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign o_mode      = mode_q;
  assign o_lives     = lives_q;
  assign o_level     = level_q;
  assign o_lane_mask = lane_mask;
  assign o_hit_lane  = hit_lane_q;
  assign o_frog_rst  = frog_rst_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Bench for frog_game_ctrl: stimulus queues the expected snapshot of every
// mode change / frog_rst pulse; a monitor pops and compares when one occurs.
module tb_frog_game_ctrl;

  localparam int HOLD = 16;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] lives;
    logic [2:0] level;
    logic [5:0] hit;
    logic       frog_rst;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       animate = 1'b0;
  logic       frog_px = 1'b0;
  logic [5:0] hazard_px = '0;
  logic       win = 1'b0;
  logic       start = 1'b0;
  logic [1:0] o_mode;
  logic [3:0] o_lives;
  logic [2:0] o_level;
  logic [5:0] o_lane_mask;
  logic [5:0] o_hit_lane;
  logic       o_frog_rst;

  int   total = 0;
  int   bad = 0;
  rec_t exp_q[$];
  logic mon_en = 1'b0;
  logic [1:0] prev_mode = 2'd0;

  frog_game_ctrl #(
    .N_LANES(6), .N_LIVES(3), .MAX_LEVEL(7), .BASE_LANES(2), .HOLD_CYCLES(HOLD)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_animate(animate), .i_frog_px(frog_px),
    .i_hazard_px(hazard_px), .i_win(win), .i_start(start),
    .o_mode(o_mode), .o_lives(o_lives), .o_level(o_level),
    .o_lane_mask(o_lane_mask), .o_hit_lane(o_hit_lane), .o_frog_rst(o_frog_rst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every mode change or frog_rst pulse must match the next queued record.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_mode != prev_mode || o_frog_rst) begin
        rec_t act;
        act = '{mode: o_mode, lives: o_lives, level: o_level, hit: o_hit_lane, frog_rst: o_frog_rst};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got %h expected none", act);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          chk("event", 32'(act), 32'(e));
        end
      end
      prev_mode = o_mode;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic f, input logic [5:0] h, input logic w);
    frog_px = f; hazard_px = h; win = w;
    tick();
    frog_px = 1'b0; hazard_px = '0; win = 1'b0;
  endtask

  task automatic frame_end(input logic f, input logic [5:0] h, input logic w);
    animate = 1'b1;
    pixel(f, h, w);
    animate = 1'b0;
  endtask

  task automatic push(input logic [1:0] m, input logic [3:0] l, input logic [2:0] lv,
                      input logic [5:0] h, input logic fr);
    rec_t r;
    r = '{mode: m, lives: l, level: lv, hit: h, frog_rst: fr};
    exp_q.push_back(r);
  endtask

  // Cycles until o_mode reaches target; overrun is reported as a failure.
  task automatic wait_mode(input logic [1:0] target, output int n);
    n = 0;
    while (o_mode != target && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) chk("wait_mode_timeout", 32'(o_mode), 32'(target));
  endtask

  function automatic logic [5:0] mask_of(input int lvl);
    int nl;
    nl = (2 + lvl > 6) ? 6 : 2 + lvl;
    return 6'((1 << nl) - 1);
  endfunction

  initial begin
    int n;
    int lvl;
    repeat (3) tick();
    rst = 1'b0;
    prev_mode = 2'd0;
    mon_en = 1'b1;

    chk("rst_mode", 32'(o_mode), 0);
    chk("rst_lives", 32'(o_lives), 3);
    chk("rst_level", 32'(o_level), 0);
    chk("rst_hit", 32'(o_hit_lane), 0);
    chk("rst_frog_rst", 32'(o_frog_rst), 0);
    chk("rst_mask", 32'(o_lane_mask), 32'h03);

    // masked lane 4 at level 0: no death
    repeat (3) pixel(1'b1, 6'b010000, 1'b0);
    frame_end(1'b1, 6'b010000, 1'b0);
    tick(); tick();
    chk("masked_mode", 32'(o_mode), 0);
    chk("masked_lives", 32'(o_lives), 3);

    // single-pixel hit on lane 1, then exact hold length
    pixel(1'b0, 6'b000010, 1'b0);
    pixel(1'b1, 6'b000010, 1'b0);
    repeat (4) pixel(1'b1, 6'b000000, 1'b0);
    push(2'd1, 4'd2, 3'd0, 6'b000010, 1'b0);
    push(2'd0, 4'd2, 3'd0, 6'b000010, 1'b1);
    frame_end(1'b0, 6'b000000, 1'b0);
    wait_mode(2'd0, n);
    chk("dead_dwell", 32'(n), HOLD);
    chk("respawn_pulse", 32'(o_frog_rst), 1);
    tick();
    chk("pulse_one_cycle", 32'(o_frog_rst), 0);

    // win and lane-0 hit in the same frame: death wins
    pixel(1'b0, 6'b000000, 1'b1);
    pixel(1'b1, 6'b000001, 1'b0);
    push(2'd1, 4'd1, 3'd0, 6'b000001, 1'b0);
    push(2'd0, 4'd1, 3'd0, 6'b000001, 1'b1);
    frame_end(1'b0, 6'b000000, 1'b0);
    wait_mode(2'd0, n);
    tick();
    chk("death_beats_win_level", 32'(o_level), 0);

    // eight wins: level saturates at 7, mask widens with level
    for (int i = 1; i <= 8; i++) begin
      lvl = (i > 7) ? 7 : i;
      push(2'd2, 4'd1, 3'((i - 1 > 7) ? 7 : i - 1), 6'b000001, 1'b0);
      push(2'd0, 4'd1, 3'(lvl), 6'b000001, 1'b1);
      pixel(1'b0, 6'b000000, 1'b1);
      frame_end(1'b0, 6'b000000, 1'b0);
      wait_mode(2'd0, n);
      tick();
      chk("win_level", 32'(o_level), 32'(lvl));
      chk("win_mask", 32'(o_lane_mask), 32'(mask_of(lvl)));
    end

    // last life lost on lane 5: OVER without a respawn pulse
    push(2'd1, 4'd0, 3'd7, 6'b100000, 1'b0);
    push(2'd3, 4'd0, 3'd7, 6'b100000, 1'b0);
    frame_end(1'b1, 6'b100000, 1'b0);
    wait_mode(2'd3, n);
    chk("over_dwell", 32'(n), HOLD);
    frame_end(1'b1, 6'b111111, 1'b1);
    repeat (3) tick();
    chk("over_holds", 32'(o_mode), 3);

    push(2'd0, 4'd3, 3'd0, 6'b000000, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_lives", 32'(o_lives), 3);
    chk("restart_hit", 32'(o_hit_lane), 0);
    tick();

    // reset five cycles into DEAD
    push(2'd1, 4'd2, 3'd0, 6'b000010, 1'b0);
    frame_end(1'b1, 6'b000010, 1'b0);
    repeat (5) tick();
    push(2'd0, 4'd3, 3'd0, 6'b000000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_dead_mode", 32'(o_mode), 0);
    chk("rst_mid_dead_lives", 32'(o_lives), 3);

    // counter restarted from 0: full hold again
    push(2'd1, 4'd2, 3'd0, 6'b000001, 1'b0);
    push(2'd0, 4'd2, 3'd0, 6'b000001, 1'b1);
    frame_end(1'b1, 6'b000001, 1'b0);
    wait_mode(2'd0, n);
    chk("post_rst_dwell", 32'(n), HOLD);

    repeat (4) tick();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
